divider_seq: RTL

Parametrised multi-cycle integer divider: one quotient bit per clock (restoring, radix-2) over a `WIDTH`-bit datapath. It supports signed and unsigned operation and detects divide-by-zero. It uses valid/ready handshakes on both the operand and result sides, so it can sit directly behind the ALU issue logic and stall the writeback stage. It is the generalised replacement for the fixed 32-bit unsigned divider.

---
 rtl/divider_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/divider_seq.sv
// divider_seq: radix-2 restoring integer divider that produces one quotient
// bit per clock, in signed or unsigned mode, with divide-by-zero detection.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, sgn sampled on accept)
//   a, b                dividend / divisor, WIDTH bits
//   sgn                 1 = two's-complement signed, 0 = unsigned
//   out_valid/out_ready result handshake
//   q, r                registered quotient / remainder
//   div_zero            result came from a zero divisor
//   busy                an operation is in flight
//
// State | Meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// CALC  | WIDTH restoring iterations, one quotient bit per cycle
// FIXUP | apply operand signs to quotient and remainder
// DONE  | result presented, waiting for out_ready
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             b_zero;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] p_sub;
    logic             take;

    assign accept = in_valid && in_ready;
    assign b_zero = (b == '0);

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            d_q     <= '0;
            bmag_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            d_q     <= d_d;
            bmag_q  <= bmag_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = b_zero ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == LAST_ITER) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath
    always_comb begin
        cnt_d  = cnt_q;
        p_d    = p_q;
        d_d    = d_q;
        bmag_d = bmag_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        q_d    = q_q;
        r_d    = r_q;
        dz_d   = dz_q;

        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        // The stored partial remainder is always below |b|, so it fits in
        // WIDTH bits; only the shifted trial value needs the extra bit.
        p_shift = {p_q, d_q[WIDTH-1]};
        take    = (p_shift >= {1'b0, bmag_q});
        p_sub   = p_shift[WIDTH-1:0] - bmag_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (b_zero) begin
                        q_d  = '1;
                        r_d  = a;
                        dz_d = 1'b1;
                    end else begin
                        sa_d   = a_neg;
                        sb_d   = b_neg;
                        bmag_d = b_mag;
                        d_d    = a_mag;
                        p_d    = '0;
                        cnt_d  = '0;
                    end
                end
            end
            S_CALC: begin
                // The dividend shifts out of d_q's MSB while quotient bits
                // fill its LSB, so d_q holds |q| after the last iteration.
                p_d   = take ? p_sub : p_shift[WIDTH-1:0];
                d_d   = {d_q[WIDTH-2:0], take};
                cnt_d = cnt_q + CW'(1);
            end
            S_FIXUP: begin
                q_d  = (sa_q ^ sb_q) ? -d_q : d_q;
                r_d  = sa_q ? -p_q : p_q;
                dz_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = dz_q;

endmodule
